// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: in-order writebacks win, long-latency results queue in a FIFO.
// Optional forced-drain on FIFO starvation is enabled by defining WB_ANTI_STARVE_EN.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_regwrite,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic                     ll_issue,
  input  logic [4:0]               ll_issue_rd,
  input  logic                     ll_valid,
  input  logic [4:0]               ll_rd,
  input  logic [31:0]              ll_data,
  output logic                     ll_ready,
  input  logic [4:0]               rs_addr,
  input  logic [4:0]               rt_addr,
  output logic                     rs_busy,
  output logic                     rt_busy,
  output logic                     wb_stall,
  output logic                     rf_regwrite,
  output logic [4:0]               rf_wreg,
  output logic [31:0]              rf_wdata,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Parameter sanity checks at elaboration
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   busy;
  logic [31:0]   busy_next;
  logic          wb_take;
  logic          pop;
  logic          enq;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  assign ll_ready = !reset && (fifo_count < CW'(DEPTH));
  assign enq      = ll_valid && ll_ready && (ll_rd != 5'd0);
  assign wb_take  = wb_regwrite && (wb_rd != 5'd0) && !wb_stall;
  assign pop      = !wb_take && (fifo_count != '0);

  assign rs_busy = (rs_addr != 5'd0) && busy[rs_addr];
  assign rt_busy = (rt_addr != 5'd0) && busy[rt_addr];

`ifdef WB_ANTI_STARVE_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign wb_stall = (starve_cnt == SW'(STARVE_LIMIT));

  // Counts cycles the FIFO head has waited behind pipeline writes
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (pop || fifo_count == '0) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign wb_stall = 1'b0;
`endif

  // Issue sets after pop clears, so a same-edge set wins
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_rd] = 1'b0;
    if (ll_issue && ll_issue_rd != 5'd0) busy_next[ll_issue_rd] = 1'b1;
  end

  // FIFO storage needs no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[wr_ptr]   <= ll_rd;
      data_mem[wr_ptr] <= ll_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      busy        <= '0;
      rf_regwrite <= 1'b0;
      rf_wreg     <= 5'd0;
      rf_wdata    <= 32'd0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      busy        <= busy_next;
      rf_regwrite <= wb_take || pop;
      if (wb_take) begin
        rf_wreg  <= wb_rd;
        rf_wdata <= wb_data;
      end else if (pop) begin
        rf_wreg  <= head_rd;
        rf_wdata <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts every register-file write.
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH = 4;
`ifdef WB_ANTI_STARVE_EN
  localparam int unsigned STARVE_LIMIT = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        wb_stall;
  logic        rf_regwrite;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;
  logic [$clog2(DEPTH):0] fifo_count;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .wb_stall(wb_stall),
    .rf_regwrite(rf_regwrite), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [36:0] exp_q[$];   // expected {rd, data} register-file writes in order
  logic [36:0] m_fifo[$];  // model of queued long-latency results
  int          pending[$]; // issued long-latency destinations not yet accepted
  bit   [31:0] m_busy;
`ifdef WB_ANTI_STARVE_EN
  int          m_wait;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must be the next predicted one
  initial begin
    logic [36:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rf_regwrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rf_write", {27'd0, rf_wreg}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rf_wreg", {27'd0, rf_wreg}, {27'd0, e[36:32]});
          chk("rf_wdata", rf_wdata, e[31:0]);
        end
      end
    end
  end

  // Check combinational outputs, advance the model by one cycle, move to next drive point
  task automatic step();
    bit take, pop, enq, rdy, stall_m;
    int pre;
    #1;
    pre     = m_fifo.size();
    stall_m = 1'b0;
`ifdef WB_ANTI_STARVE_EN
    stall_m = (pre != 0) && (m_wait == STARVE_LIMIT);
`endif
    rdy = !reset && (pre < DEPTH);
    chk("wb_stall", 32'(wb_stall), 32'(stall_m));
    chk("ll_ready", 32'(ll_ready), 32'(rdy));
    chk("fifo_count", 32'(fifo_count), 32'(pre));
    chk("rs_busy", 32'(rs_busy), 32'(rs_addr != 0 && m_busy[rs_addr]));
    chk("rt_busy", 32'(rt_busy), 32'(rt_addr != 0 && m_busy[rt_addr]));
    if (reset) begin
      m_fifo.delete();
      pending.delete();
      m_busy = '0;
`ifdef WB_ANTI_STARVE_EN
      m_wait = 0;
`endif
    end else begin
      take = wb_regwrite && wb_rd != 0 && !stall_m;
      pop  = !take && pre != 0;
      enq  = ll_valid && rdy && ll_rd != 0;
      if (take) begin
        exp_q.push_back({wb_rd, wb_data});
      end else if (pop) begin
        exp_q.push_back(m_fifo[0]);
        m_busy[m_fifo[0][36:32]] = 1'b0;
        void'(m_fifo.pop_front());
      end
      if (enq) begin
        m_fifo.push_back({ll_rd, ll_data});
        for (int i = 0; i < pending.size(); i++)
          if (pending[i] == int'(ll_rd)) begin
            pending.delete(i);
            break;
          end
      end
      if (ll_issue && ll_issue_rd != 0) begin
        m_busy[ll_issue_rd] = 1'b1;
        pending.push_back(int'(ll_issue_rd));
      end
`ifdef WB_ANTI_STARVE_EN
      m_wait = (pop || pre == 0) ? 0 : m_wait + 1;
`endif
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wb_regwrite = 1'b0;
    ll_issue    = 1'b0;
    ll_valid    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    wb_rd = 0; wb_data = 0; ll_issue_rd = 0; ll_rd = 0; ll_data = 0;
    rs_addr = 0; rt_addr = 0;
    m_busy = '0;
`ifdef WB_ANTI_STARVE_EN
    m_wait = 0;
`endif
    idle();
    repeat (3) @(negedge clk);
    chk("reset_rf_regwrite", 32'(rf_regwrite), 32'd0);
    chk("reset_rf_wreg", 32'(rf_wreg), 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_fifo_count", 32'(fifo_count), 32'd0);
    chk("reset_ll_ready", 32'(ll_ready), 32'd0);
    reset = 1'b0;
    step();

    // Plain pipeline writeback
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5_0001;
    step();
    idle(); step();

    // Single long-latency op with busy query
    ll_issue = 1'b1; ll_issue_rd = 5'd9; rs_addr = 5'd9; rt_addr = 5'd9;
    step();
    ll_issue = 1'b0; step();
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h0000_1234;
    step();
    idle(); repeat (3) step();

    // Fill FIFO behind continuous writebacks, then one rejected extra result
    for (int i = 0; i <= DEPTH; i++) begin
      ll_issue = 1'b1; ll_issue_rd = 5'(10 + i); step();
    end
    ll_issue = 1'b0; rs_addr = 5'd10; rt_addr = 5'(10 + DEPTH);
    wb_regwrite = 1'b1; wb_rd = 5'd3;
    for (int i = 0; i <= DEPTH; i++) begin
      ll_valid = 1'b1; ll_rd = 5'(10 + i); ll_data = 32'hC000_0000 + 32'(i);
      wb_data = $urandom; step();
    end
    idle(); repeat (DEPTH + 1) step();
    ll_valid = 1'b1; ll_rd = 5'(10 + DEPTH); ll_data = 32'hC0DE_0004; step();
    idle(); repeat (3) step();

    // r0 writes are dropped on both paths
    wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_0000;
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'hDEAD_0001;
    repeat (2) step();
    idle(); step();

    // One queued result behind a long run of writebacks
    ll_issue = 1'b1; ll_issue_rd = 5'd20; rs_addr = 5'd20; step();
    ll_issue = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd20; ll_data = 32'h2020_2020;
    wb_regwrite = 1'b1; wb_rd = 5'd4;
    for (int i = 0; i < 14; i++) begin
      wb_data = 32'h4000_0000 + 32'(i); step();
      ll_valid = 1'b0;
    end
    idle(); repeat (2) step();

    // Reset with three queued results and busy bits set
    for (int i = 0; i < 3; i++) begin
      ll_issue = 1'b1; ll_issue_rd = 5'(21 + i); step();
    end
    ll_issue = 1'b0; rs_addr = 5'd21; rt_addr = 5'd22;
    wb_regwrite = 1'b1; wb_rd = 5'd4;
    for (int i = 0; i < 3; i++) begin
      ll_valid = 1'b1; ll_rd = 5'(21 + i); ll_data = 32'h2100_0000 + 32'(i);
      wb_data = $urandom; step();
    end
    ll_valid = 1'b0; step();
    idle(); reset = 1'b1; step();
    reset = 1'b0; repeat (3) step();

    // Randomized traffic honouring the decode contract
    for (int c = 0; c < 400; c++) begin
      wb_regwrite = ($urandom % 2) == 0;
      wb_rd       = 5'($urandom);
      wb_data     = $urandom;
      if (wb_rd != 0 && m_busy[wb_rd]) wb_regwrite = 1'b0;
      ll_issue    = ($urandom % 5) == 0;
      ll_issue_rd = 5'($urandom);
      if (m_busy[ll_issue_rd]) ll_issue = 1'b0;
      ll_data     = $urandom;
      if (pending.size() > 0 && ($urandom % 5) < 2) begin
        ll_valid = 1'b1;
        ll_rd    = 5'(pending[$urandom_range(pending.size() - 1, 0)]);
      end else begin
        ll_valid = ($urandom % 10) == 0;
        ll_rd    = 5'd0;
      end
      rs_addr = 5'($urandom);
      rt_addr = 5'($urandom);
      step();
    end

    // Drain all outstanding results, bounded
    idle();
    for (int c = 0; c < 40 && (m_fifo.size() != 0 || exp_q.size() != 0); c++) step();
    chk("drain_expected_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
